// File: rtl/dma_priority_arb.sv
// dma_priority_arb: request/grant arbiter for a 4-channel DMA controller.
//
// Combines hardware (DREQ) and software (requestReg) requests.
// Raises HRQ to the CPU and waits for HLDA.
// Picks one channel, using fixed or rotating priority.
// Holds the grant until the transfer FSM pulses xferDone.
// Releases the bus when the grant ends.
//
// Ports
//   CLK         clock, rising edge active
//   RESET       asynchronous reset, active low
//   DREQ[3:0]   raw channel requests, sense selected by commandReg[6]
//   commandReg  [2] disable, [4] rotating priority, [6] DREQ active-low,
//               [7] DACK active-high
//   requestReg  software request per channel (bypasses the mask)
//   maskReg     per-channel hardware request mask (1 = masked)
//   HLDA        hold acknowledge from the CPU
//   xferDone    one-cycle pulse ending the current service
//   HRQ         hold request to the CPU
//   DACK[3:0]   channel acknowledge, polarity from commandReg[7]
//   grantValid  high while a channel is being serviced
//   grantCh     serviced channel number
//   swReqClr    one-cycle pulse clearing the serviced software request
module dma_priority_arb (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] DREQ,
   input  logic [7:0] commandReg,
   input  logic [3:0] requestReg,
   input  logic [3:0] maskReg,
   input  logic       HLDA,
   input  logic       xferDone,
   output logic       HRQ,
   output logic [3:0] DACK,
   output logic       grantValid,
   output logic [1:0] grantCh,
   output logic [3:0] swReqClr
);

   typedef enum logic [1:0] {StIdle, StReq, StGrant, StRelease} state_e;

   state_e     state_q, state_d;
   logic       hrq_q, hrq_d;
   logic       gv_q, gv_d;
   logic [1:0] ch_q, ch_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] ack_q, ack_d;   // one-hot active-high acknowledge
   logic [3:0] clr_q, clr_d;

   logic [3:0] eff_req;
   logic       any_req;
   logic [1:0] winner;
   logic [1:0] base;
   logic [1:0] cand;
   logic       found;

   assign eff_req = ((DREQ ^ {4{commandReg[6]}}) & ~maskReg) | requestReg;
   assign any_req = |eff_req;

   // The search starts one channel after base.
   // In fixed mode base is 3, so channel 0 is checked first.
   always_comb begin
      base   = commandReg[4] ? ptr_q : 2'd3;
      winner = 2'd0;
      found  = 1'b0;
      cand   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = base + k[1:0];
         if (!found && eff_req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hrq_d   = hrq_q;
      gv_d    = gv_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      ack_d   = ack_q;
      clr_d   = 4'b0000;
      unique case (state_q)
         StIdle: begin
            if (any_req && !commandReg[2]) begin
               state_d = StReq;
               hrq_d   = 1'b1;
            end
         end
         StReq: begin
            // Request withdrawal or disable takes precedence over a late HLDA.
            if (!any_req || commandReg[2]) begin
               state_d = StIdle;
               hrq_d   = 1'b0;
            end else if (HLDA) begin
               state_d = StGrant;
               ch_d    = winner;
               ack_d   = 4'b0001 << winner;
               gv_d    = 1'b1;
            end
         end
         StGrant: begin
            if (xferDone) begin
               state_d         = StRelease;
               ack_d           = 4'b0000;
               gv_d            = 1'b0;
               hrq_d           = 1'b0;
               ptr_d           = ch_q;
               clr_d[ch_q]     = requestReg[ch_q];
            end
         end
         StRelease: begin
            if (!HLDA) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= StIdle;
         hrq_q   <= 1'b0;
         gv_q    <= 1'b0;
         ch_q    <= 2'd0;
         ptr_q   <= 2'd3;
         ack_q   <= 4'b0000;
         clr_q   <= 4'b0000;
      end else begin
         state_q <= state_d;
         hrq_q   <= hrq_d;
         gv_q    <= gv_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         clr_q   <= clr_d;
      end
   end

   assign HRQ        = hrq_q;
   assign grantValid = gv_q;
   assign grantCh    = ch_q;
   assign swReqClr   = clr_q;
   // Inactive bits follow the live sense bit; the active bit is stored one-hot.
   assign DACK       = commandReg[7] ? ack_q : ~ack_q;

endmodule

// File: tb/tb_dma_priority_arb.sv
// tb_dma_priority_arb: directed scenarios plus a randomized run.
// All results are checked against a behavioural model of the arbiter.
module tb_dma_priority_arb;

   logic       CLK;
   logic       RESET;
   logic [3:0] DREQ;
   logic [7:0] commandReg;
   logic [3:0] requestReg;
   logic [3:0] maskReg;
   logic       HLDA;
   logic       xferDone;
   logic       HRQ;
   logic [3:0] DACK;
   logic       grantValid;
   logic [1:0] grantCh;
   logic [3:0] swReqClr;

   int n_cmp = 0;
   int n_err = 0;

   dma_priority_arb dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .DREQ       (DREQ),
      .commandReg (commandReg),
      .requestReg (requestReg),
      .maskReg    (maskReg),
      .HLDA       (HLDA),
      .xferDone   (xferDone),
      .HRQ        (HRQ),
      .DACK       (DACK),
      .grantValid (grantValid),
      .grantCh    (grantCh),
      .swReqClr   (swReqClr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- behavioural model ----------------
   // The phase encodes where the model is in the handshake:
   //   0 = idle, 1 = waiting for HLDA, 2 = serving, 3 = waiting for HLDA to drop.
   int         m_phase;
   int         m_last;
   logic       m_hrq;
   logic       m_gv;
   logic [1:0] m_ch;
   logic [3:0] m_ack;
   logic [3:0] m_clr;
   logic [3:0] m_eff;

   function automatic logic [1:0] pick(input logic [3:0] eff, input logic rot, input int last);
      int start;
      start = rot ? (last + 1) % 4 : 0;
      for (int k = 0; k < 4; k++) begin
         if (eff[(start + k) % 4]) return 2'((start + k) % 4);
      end
      return 2'd0;
   endfunction

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_phase = 0;
         m_last  = 3;
         m_hrq   = 1'b0;
         m_gv    = 1'b0;
         m_ch    = 2'd0;
         m_ack   = 4'b0000;
         m_clr   = 4'b0000;
      end else begin
         m_eff = 4'b0000;
         for (int n = 0; n < 4; n++) begin
            m_eff[n] = ((DREQ[n] != commandReg[6]) && !maskReg[n]) || requestReg[n];
         end
         m_clr = 4'b0000;
         if (m_phase == 0) begin
            if (m_eff != 0 && !commandReg[2]) begin
               m_phase = 1;
               m_hrq   = 1'b1;
            end
         end else if (m_phase == 1) begin
            if (m_eff == 0 || commandReg[2]) begin
               m_phase = 0;
               m_hrq   = 1'b0;
            end else if (HLDA) begin
               m_ch    = pick(m_eff, commandReg[4], m_last);
               m_ack   = 4'b0000;
               m_ack[m_ch] = 1'b1;
               m_gv    = 1'b1;
               m_phase = 2;
            end
         end else if (m_phase == 2) begin
            if (xferDone) begin
               m_clr[m_ch] = requestReg[m_ch];
               m_last  = int'(m_ch);
               m_ack   = 4'b0000;
               m_gv    = 1'b0;
               m_hrq   = 1'b0;
               m_phase = 3;
            end
         end else begin
            if (!HLDA) m_phase = 0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      logic [3:0] exp_dack;
      exp_dack = commandReg[7] ? m_ack : ~m_ack;
      chk("model HRQ", 8'(HRQ), 8'(m_hrq));
      chk("model grantValid", 8'(grantValid), 8'(m_gv));
      chk("model grantCh", 8'(grantCh), 8'(m_ch));
      chk("model swReqClr", 8'(swReqClr), 8'(m_clr));
      chk("model DACK", 8'(DACK), 8'(exp_dack));
   endtask

   // Advance to the next falling edge and compare everything against the model.
   task automatic step();
      @(negedge CLK);
      cmp_all();
   endtask

   task automatic do_reset();
      RESET      = 1'b0;
      DREQ       = 4'b0000;
      commandReg = 8'h00;
      requestReg = 4'b0000;
      maskReg    = 4'b0000;
      HLDA       = 1'b0;
      xferDone   = 1'b0;
      step();
      step();
      RESET = 1'b1;
      step();
   endtask

   // Full handshake from idle with requests already present.
   task automatic service(input logic [1:0] exp_ch, input logic [3:0] exp_clr);
      step();
      chk("svc HRQ raised", 8'(HRQ), 8'h01);
      HLDA = 1'b1;
      step();
      chk("svc grantCh", 8'(grantCh), 8'(exp_ch));
      chk("svc grantValid", 8'(grantValid), 8'h01);
      xferDone = 1'b1;
      step();
      xferDone = 1'b0;
      chk("svc swReqClr pulse", 8'(swReqClr), 8'(exp_clr));
      chk("svc HRQ dropped", 8'(HRQ), 8'h00);
      HLDA       = 1'b0;
      requestReg = 4'b0000;
      step();
      chk("svc swReqClr cleared", 8'(swReqClr), 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1;
      DREQ = 4'b0000; commandReg = 8'h00; requestReg = 4'b0000; maskReg = 4'b0000;
      HLDA = 1'b0; xferDone = 1'b0;
      #2;

      // Reset state
      do_reset();
      chk("reset HRQ", 8'(HRQ), 8'h00);
      chk("reset grantValid", 8'(grantValid), 8'h00);
      chk("reset grantCh", 8'(grantCh), 8'h00);
      chk("reset DACK", 8'(DACK), 8'h0f);

      // Fixed priority, HLDA two cycles after HRQ
      DREQ = 4'b0101;
      step();
      chk("fixed HRQ one edge", 8'(HRQ), 8'h01);
      step();
      HLDA = 1'b1;
      step();
      chk("fixed grantCh", 8'(grantCh), 8'h00);
      chk("fixed DACK", 8'(DACK), 8'h0e);
      xferDone = 1'b1;
      step();
      xferDone = 1'b0;
      chk("fixed HRQ after done", 8'(HRQ), 8'h00);
      chk("fixed DACK after done", 8'(DACK), 8'h0f);
      HLDA = 1'b0;
      DREQ = 4'b0000;
      step();
      step();

      // Rotating priority
      do_reset();
      commandReg = 8'h10;
      DREQ       = 4'b1111;
      service(2'd0, 4'b0000);
      service(2'd1, 4'b0000);
      service(2'd2, 4'b0000);
      service(2'd3, 4'b0000);
      service(2'd0, 4'b0000);
      DREQ = 4'b0000;
      step();

      // Mask and software request
      do_reset();
      maskReg = 4'b0001;
      DREQ    = 4'b0001;
      step();
      step();
      step();
      chk("masked HRQ low", 8'(HRQ), 8'h00);
      requestReg = 4'b0001;
      service(2'd0, 4'b0001);
      step();
      chk("masked no rerequest", 8'(HRQ), 8'h00);

      // Request withdrawal
      do_reset();
      DREQ = 4'b0001;
      step();
      chk("withdraw HRQ high", 8'(HRQ), 8'h01);
      DREQ = 4'b0000;
      step();
      chk("withdraw HRQ low", 8'(HRQ), 8'h00);
      chk("withdraw DACK idle", 8'(DACK), 8'h0f);
      step();
      chk("withdraw HRQ stays low", 8'(HRQ), 8'h00);

      // Polarity and disable during GRANT
      do_reset();
      commandReg = 8'hC0;
      DREQ       = 4'b1101;
      step();
      HLDA = 1'b1;
      step();
      chk("polarity grantCh", 8'(grantCh), 8'h01);
      chk("polarity DACK", 8'(DACK), 8'h02);
      commandReg = 8'hC4;
      step();
      chk("disable DACK held", 8'(DACK), 8'h02);
      xferDone = 1'b1;
      step();
      xferDone = 1'b0;
      chk("disable DACK released", 8'(DACK), 8'h00);
      chk("disable grantValid", 8'(grantValid), 8'h00);
      HLDA = 1'b0;
      step();
      step();
      step();
      chk("disable no new HRQ", 8'(HRQ), 8'h00);

      // Reset during GRANT of channel 2
      do_reset();
      DREQ       = 4'b0100;
      requestReg = 4'b0100;
      step();
      HLDA = 1'b1;
      step();
      chk("midreset grantCh", 8'(grantCh), 8'h02);
      #2 RESET = 1'b0;
      #1;
      chk("midreset HRQ async", 8'(HRQ), 8'h00);
      chk("midreset grantValid async", 8'(grantValid), 8'h00);
      xferDone = 1'b1;
      step();
      RESET      = 1'b1;
      xferDone   = 1'b0;
      HLDA       = 1'b0;
      requestReg = 4'b0000;
      DREQ       = 4'b0000;
      step();
      chk("midreset no swReqClr", 8'(swReqClr), 8'h00);

      // Randomized run
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) == 0) begin
            #2 RESET = 1'b0;
            step();
            RESET = 1'b1;
         end
         DREQ          = 4'($urandom);
         commandReg    = 8'($urandom);
         commandReg[2] = ($urandom_range(9) == 0);
         maskReg       = 4'($urandom) & 4'($urandom);
         requestReg    = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
         HLDA          = m_hrq ? ($urandom_range(2) != 0) : ($urandom_range(3) == 0);
         xferDone      = ($urandom_range(3) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
